// File: rtl/buffer_pkg.sv
// Shared constants and sizing helpers for the scratch-buffer write controller.
// No logic of its own: only compile-time functions and default parameter values.
// Ports: none.
package buffer_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PAR_WRITE_DEF  = 2;
  localparam int PAR_READ_DEF   = 3;

  // Number of words held by a buffer with the given address width.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

  // Lane index width; a single-lane pack still needs a 1-bit counter.
  function automatic int lane_width(input int pw);
    int w;
    w = $clog2(pw);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/buffer_write_ctrl_ring_ptr.sv
// Purpose: modulo-2**WIDTH pointer that advances by STEP when adv is high.
// Latency: pointer updates on the edge where adv is sampled; clr wins over adv.
// Backpressure: none; the owner decides when to advance.
// Ports: clk, rst (async, active high), clr (sync), adv, ptr.
module ring_ptr #(
  parameter int WIDTH = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [WIDTH-1:0] ptr
);

  // Truncation to WIDTH bits is the modulo-DEPTH wrap.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr + STEP_W;
    end
  end

endmodule

// File: rtl/buffer_write_ctrl.sv
// Purpose: packs a 1-word/cycle stream into PAR_WRITE-word buffer writes and runs the buffer as a circular queue.
// Latency: last word of a group accepted -> wen/waddr/din next edge -> counted (readable) on the following edge.
// Backpressure: only the group-completing word stalls, when free space (minus the write in flight) < PAR_WRITE.
// Ports: clk, rst, clr | in_valid/in_ready/in_data stream | wen/waddr/din buffer write |
//        raddr/rd_avail/rel consumer side | count, full status.
module buffer_write_ctrl
  import buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PAR_WRITE  = PAR_WRITE_DEF,
  parameter int PAR_READ   = PAR_READ_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            wen,
  output logic [ADDR_WIDTH-1:0]           waddr,
  output logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0]           raddr,
  output logic                            rd_avail,
  input  logic                            rel,
  output logic [ADDR_WIDTH:0]             count,
  output logic                            full
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam int LW    = lane_width(PAR_WRITE);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] PW_C      = CW'(PAR_WRITE);
  localparam logic [CW-1:0] PR_C      = CW'(PAR_READ);
  localparam logic [LW-1:0] LAST_LANE = LW'(PAR_WRITE - 1);

  logic [LW-1:0]                   lane;
  logic [PAR_WRITE*DATA_WIDTH-1:0] pack;
  logic [PAR_WRITE*DATA_WIDTH-1:0] din_next;
  logic [ADDR_WIDTH-1:0]           wptr;
  logic [ADDR_WIDTH-1:0]           rptr;
  logic [CW-1:0]                   space;
  logic                            accept;
  logic                            complete;
  logic                            rel_fire;

  // The write in flight has not been counted yet, so its words are reserved
  // here; otherwise a back-to-back group could overrun unreleased data.
  always_comb begin
    space = DEPTH_C - count - (wen ? PW_C : '0);
  end

  assign full     = (space < PW_C);
  assign in_ready = (lane != LAST_LANE) || (space >= PW_C);
  assign rd_avail = (count >= PR_C);
  assign raddr    = rptr;

  assign accept   = in_valid && in_ready;
  assign complete = accept && (lane == LAST_LANE);
  assign rel_fire = rel && rd_avail;

  // The completing word goes straight to the top lane; it is never stored.
  always_comb begin
    din_next = pack;
    din_next[(PAR_WRITE-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= '0;
      pack  <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      din   <= '0;
      count <= '0;
    end else if (clr) begin
      lane  <= '0;
      pack  <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      din   <= '0;
      count <= '0;
    end else begin
      wen <= complete;
      if (complete) begin
        lane  <= '0;
        din   <= din_next;
        waddr <= wptr;
      end else if (accept) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
          if (lane == LW'(i)) begin
            pack[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
          end
        end
        lane <= lane + LW'(1);
      end
      // Commit and release can land on the same edge; fold both in one update.
      count <= count + (wen ? PW_C : '0) - (rel_fire ? PR_C : '0);
    end
  end

  ring_ptr #(
    .WIDTH (ADDR_WIDTH),
    .STEP  (PAR_WRITE)
  ) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (complete),
    .ptr (wptr)
  );

  ring_ptr #(
    .WIDTH (ADDR_WIDTH),
    .STEP  (PAR_READ)
  ) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (rel_fire),
    .ptr (rptr)
  );

endmodule

// File: tb/tb_buffer_write_ctrl.sv
// Bench for buffer_write_ctrl at default parameters (AW=3, DW=8, PW=2, PR=3).
// Write expectations are queued by the stimulus and popped by a monitor on each wen.
// A small memory model stands in for the scratch buffer to check wrap-around placement.
module tb_buffer_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        wen;
  logic [2:0]  waddr;
  logic [15:0] din;
  logic [2:0]  raddr;
  logic        rd_avail;
  logic        rel = 1'b0;
  logic [3:0]  count;
  logic        full;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem [8];
  int         checks = 0;
  int         errors = 0;

  buffer_write_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wen      (wen),
    .waddr    (waddr),
    .din      (din),
    .raddr    (raddr),
    .rd_avail (rd_avail),
    .rel      (rel),
    .count    (count),
    .full     (full)
  );

  always #5 clk = ~clk;

  // Scratch buffer stand-in: lanes wrap individually through 3-bit truncation.
  always @(posedge clk) begin
    if (!rst && wen) begin
      for (int i = 0; i < 2; i++) mem[3'(waddr + 3'(i))] <= din[i*8 +: 8];
    end
  end

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wen) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got waddr=%0h din=%0h, required no write", waddr, din);
      end else begin
        e = exp_q.pop_front();
        if (waddr !== e.a || din !== e.d) begin
          errors++;
          $display("FAIL write: got waddr=%0h din=%0h, required waddr=%0h din=%0h", waddr, din, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0; in_valid = 1'b0; rel = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hold one word until accepted; in_ready is sampled mid-cycle before each edge.
  task automatic push(input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: got no accept for %0h, required accept within 50 cycles", d);
    end
  endtask

  task automatic pulse_rel();
    rel = 1'b1;
    tick();
    rel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_count",    32'(count),    0);
    chk("rst_rd_avail", 32'(rd_avail), 0);
    chk("rst_full",     32'(full),     0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_raddr",    32'(raddr),    0);
    chk("rst_wen",      32'(wen),      0);
    chk("rst_din",      32'(din),      0);

    // Single group: write next edge, counted the edge after
    push(8'h11);
    push(8'h22);
    expect_wr(3'd0, 16'h2211);
    chk("t1_wen_now",    32'(wen),   1);
    chk("t1_count_pre",  32'(count), 0);
    tick();
    chk("t1_count",      32'(count),    2);
    chk("t1_rd_avail",   32'(rd_avail), 0);
    chk("t1_wen_pulse",  32'(wen),      0);

    // Group read and release
    do_reset();
    push(8'h01); push(8'h02); expect_wr(3'd0, 16'h0201);
    push(8'h03); push(8'h04); expect_wr(3'd2, 16'h0403);
    tick();
    chk("t2_count",    32'(count),    4);
    chk("t2_rd_avail", 32'(rd_avail), 1);
    chk("t2_raddr",    32'(raddr),    0);
    chk("t2_mem0",     32'(mem[0]),   8'h01);
    chk("t2_mem2",     32'(mem[2]),   8'h03);
    pulse_rel();
    chk("t2_rel_count",    32'(count),    1);
    chk("t2_rel_raddr",    32'(raddr),    3);
    chk("t2_rel_rd_avail", 32'(rd_avail), 0);
    pulse_rel();
    chk("t2_ign_count", 32'(count), 1);
    chk("t2_ign_raddr", 32'(raddr), 3);

    // Full stall: only the completing word waits for space
    do_reset();
    push(8'h31); push(8'h32); expect_wr(3'd0, 16'h3231);
    push(8'h33); push(8'h34); expect_wr(3'd2, 16'h3433);
    push(8'h35); push(8'h36); expect_wr(3'd4, 16'h3635);
    push(8'h37); push(8'h38); expect_wr(3'd6, 16'h3837);
    push(8'h39);
    tick();
    chk("t3_count", 32'(count), 8);
    chk("t3_full",  32'(full),  1);
    in_valid = 1'b1;
    in_data  = 8'h3A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(in_ready), 0);
      tick();
    end
    rel = 1'b1;
    @(negedge clk);
    chk("t3_stall_ready_rel", 32'(in_ready), 0);
    tick();
    rel = 1'b0;
    chk("t3_rel_count", 32'(count), 5);
    chk("t3_rel_full",  32'(full),  0);
    push(8'h3A); expect_wr(3'd0, 16'h3A39);
    tick();
    chk("t3_final_count", 32'(count), 7);

    // Wrap: second pass writes at 6 then 0, reads straddle the top
    do_reset();
    push(8'h41); push(8'h42); expect_wr(3'd0, 16'h4241);
    push(8'h43); push(8'h44); expect_wr(3'd2, 16'h4443);
    push(8'h45); push(8'h46); expect_wr(3'd4, 16'h4645);
    tick();
    chk("t4_count6", 32'(count), 6);
    pulse_rel();
    pulse_rel();
    chk("t4_count0", 32'(count), 0);
    chk("t4_raddr6", 32'(raddr), 6);
    push(8'h0A); push(8'h0B); expect_wr(3'd6, 16'h0B0A);
    push(8'h0C); push(8'h0D); expect_wr(3'd0, 16'h0D0C);
    tick();
    chk("t4_count4",   32'(count),    4);
    chk("t4_rd_avail", 32'(rd_avail), 1);
    chk("t4_mem6",     32'(mem[6]),   8'h0A);
    chk("t4_mem7",     32'(mem[7]),   8'h0B);
    chk("t4_mem0",     32'(mem[0]),   8'h0C);

    // Commit and release on the same edge
    do_reset();
    push(8'h51); push(8'h52); expect_wr(3'd0, 16'h5251);
    push(8'h53); push(8'h54); expect_wr(3'd2, 16'h5453);
    push(8'h55); push(8'h56); expect_wr(3'd4, 16'h5655);
    tick();
    pulse_rel();
    chk("t5_count3", 32'(count), 3);
    push(8'h57); push(8'h58); expect_wr(3'd6, 16'h5857);
    pulse_rel();
    chk("t5_count2", 32'(count), 2);
    chk("t5_raddr6", 32'(raddr), 6);

    // Synchronous clear drops the pending commit and overrides an input word
    do_reset();
    push(8'h61); push(8'h62); expect_wr(3'd0, 16'h6261);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("t6_wen",      32'(wen),      0);
    chk("t6_count",    32'(count),    0);
    chk("t6_raddr",    32'(raddr),    0);
    chk("t6_in_ready", 32'(in_ready), 1);
    tick();
    chk("t6_count_after", 32'(count), 0);
    push(8'h63);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    push(8'h64); push(8'h65); expect_wr(3'd0, 16'h6564);
    tick();
    chk("t6_count2", 32'(count), 2);

    // Asynchronous reset between edges
    do_reset();
    push(8'h71); push(8'h72);
    chk("t7_wen_pending", 32'(wen), 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_wen",   32'(wen),   0);
    chk("t7_async_din",   32'(din),   0);
    chk("t7_async_count", 32'(count), 0);
    tick();
    rst = 1'b0;
    push(8'h73);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_ready", 32'(in_ready), 1);
    tick();
    rst = 1'b0;
    push(8'h81); push(8'h82); expect_wr(3'd0, 16'h8281);
    tick();
    chk("t7_count", 32'(count),  2);
    chk("t7_mem0",  32'(mem[0]), 8'h81);
    chk("t7_mem1",  32'(mem[1]), 8'h82);

    repeat (3) tick();
    chk("pending_writes", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_write_ctrl.md
Name: buffer_write_ctrl

Overview:
Upstream feeder for the shared parallel-port scratch buffer (write PAR_WRITE words per cycle, read PAR_READ words combinationally at raddr).
- Accepts a one-word-per-cycle stream with valid/ready.
- Packs PAR_WRITE words into one wide write and drives the buffer's wen/waddr/din.
- Runs the buffer as a circular queue: owns both the write and read pointers and tracks occupancy.
- Tells the downstream consumer when a PAR_READ-word group is readable, and retires that group on a release pulse.

Parameters:
- ADDR_WIDTH, 3, buffer address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.
- PAR_WRITE, 2, words per buffer write; must satisfy 1 <= PAR_WRITE <= DEPTH.
- PAR_READ, 3, words per consumer group; must satisfy 1 <= PAR_READ <= DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of pointers, count and partial pack.
- in_valid  in  1  input word valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  input word.
- wen  out  1  buffer write enable (registered).
- waddr  out  ADDR_WIDTH  buffer write base address (registered).
- din  out  PAR_WRITE*DATA_WIDTH  packed write data; lane i = bits [(i+1)*DW-1 : i*DW] (registered).
- raddr  out  ADDR_WIDTH  buffer read base address = read pointer.
- rd_avail  out  1  count >= PAR_READ.
- rel  in  1  consumer release of one PAR_READ group.
- count  out  ADDR_WIDTH+1  committed words in the buffer.
- full  out  1  space < PAR_WRITE.

Behaviour:
- Reset (rst=1, asynchronous) and clr (synchronous, overrides all other inputs that cycle):
  - lane=0, pack register=0, wen=0, waddr=0, din=0, rptr=0, count=0.
  - Resulting outputs: raddr=0, rd_avail=0, full=0, in_ready=1.
- Definitions:
  - space = DEPTH - count - (wen ? PAR_WRITE : 0). The write in flight is reserved.
  - in_ready = (lane != PAR_WRITE-1) || (space >= PAR_WRITE).
  - full = (space < PAR_WRITE).
- Packing:
  - An accepted word is stored in lane[lane] and lane increments.
  - When the accepted word completes lane PAR_WRITE-1, the next edge does all of: lane -> 0; din <= {in_data, stored lanes}; wen <= 1; waddr <= wptr; wptr <= (wptr + PAR_WRITE) mod DEPTH.
  - Otherwise wen <= 0. wen is a single-cycle pulse per group.
  - If a group completes while wen is already 1, wen stays 1 for back-to-back groups.
- Commit:
  - The buffer latches data on the edge where wen=1. count += PAR_WRITE on that same edge.
  - Consequence: rd_avail never rises before the data is in memory.
  - Latency from the last accepted word to data being readable is 2 edges.
- Release:
  - On an edge with rel && rd_avail: rptr <= (rptr + PAR_READ) mod DEPTH and count -= PAR_READ.
  - rel while rd_avail=0 is ignored.
- Simultaneous commit and release: count <= count + PAR_WRITE - PAR_READ in one update.
- Wrap-around:
  - Pointers wrap modulo DEPTH.
  - Groups that straddle the top address wrap per lane through ADDR_WIDTH truncation in the buffer (e.g. waddr=7 with PAR_WRITE=2 writes words 7 and 0).
  - No alignment of waddr or raddr is required.
- Full:
  - Lanes 0..PAR_WRITE-2 always accept, since they only fill the pack register.
  - Only the completing word stalls.
- Partial pack: a partial pack is never written out on its own. Only clr or rst discards it.
- Reset mid-operation: any pending wen is dropped and the queue is empty. Buffer contents are irrelevant.

Decomposition:
- Shared package buffer_pkg:
  - DEPTH computed as 2**ADDR_WIDTH.
  - Count width constant ADDR_WIDTH+1.
  - Lane-counter width function clog2(PAR_WRITE), with a minimum of 1.
- One small sub-module, ring_ptr: a modulo-DEPTH pointer with an advance-by-STEP input and a clear.
  - Instantiated twice: STEP=PAR_WRITE for the write pointer, STEP=PAR_READ for the read pointer.
- The pack register and the count/space logic stay in the top module.

Test Plan:
- Single group: rst, then push 0x11 and 0x22 on consecutive cycles. One edge later: wen=1, waddr=0, din=0x2211. Next edge: count=2, rd_avail=0.
- Group read: push 0x01..0x04. After both commits: count=4, rd_avail=1, raddr=0. Pulse rel: count=1, raddr=3, rd_avail=0. A further rel leaves count=1.
- Full stall: push 10 words with no rel. Words 1-8 commit (count=8, full=1). Word 9 is accepted into lane 0. Word 10 sees in_ready=0 until a rel; after rel, count=5 then 7 when that group commits.
- Wrap: push 6, rel twice (count=0, raddr=6), then push 0xA..0xD. Write groups go to waddr=6 then waddr=0. Buffer dout at raddr=6 reads 0xA, 0xB, 0xC (words 6, 7, 0).
- Simultaneous events: count=3, a group completes (wen=1) and rel is pulsed on the commit edge. Result: count=2, raddr advanced by 3.
- Clear/reset mid-operation: with lane=1 and wen=1 pending, assert clr for 1 cycle. wen=0, count=0, raddr=0, and the partial word is discarded. The next two words write at waddr=0. Repeat with an asynchronous rst pulse mid-cycle: outputs clear immediately, without waiting for a clock edge.
